// File: rtl/match_sequencer.sv
// Match round/score controller: attract, serve countdown, play, point pause, game over. Optional macro MATCH_SEQUENCER_SCORE_LEDS_EN selects score LEDs instead of one-hot state LEDs.
// Latency: all outputs registered; a start edge or miss pulse is reflected the cycle after it is sampled.
// Backpressure: none; pulse inputs are consumed in the cycle they arrive or ignored.
module match_sequencer #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int FRAME_CNT_W  = 8,
   parameter int LEDS_W       = 8
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               new_frame_i,
   input  logic               start_i,
   input  logic               miss_left_i,
   input  logic               miss_right_i,
   output logic               ball_run_o,
   output logic               ball_reset_o,
   output logic               serve_dir_o,
   output logic [SCORE_W-1:0] score_l_o,
   output logic [SCORE_W-1:0] score_r_o,
   output logic [1:0]         winner_o,
   output logic [2:0]         state_o,
   output logic [LEDS_W-1:0]  leds_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SERVE = 3'd1,
      S_PLAY  = 3'd2,
      S_POINT = 3'd3,
      S_OVER  = 3'd4
   } state_t;

   localparam logic [FRAME_CNT_W-1:0] SERVE_CNT = FRAME_CNT_W'(SERVE_FRAMES);
   localparam logic [FRAME_CNT_W-1:0] POINT_CNT = FRAME_CNT_W'(POINT_FRAMES);
   localparam logic [SCORE_W-1:0]     WIN      = SCORE_W'(WIN_SCORE);

   state_t                 state, state_n;
   logic                   start_q;
   logic                   start_edge;
   logic [FRAME_CNT_W-1:0] frame_cnt, frame_cnt_n, frame_step;
   logic [SCORE_W-1:0]     score_l, score_l_n, score_r, score_r_n;
   logic                   serve_dir, serve_dir_n;
   logic [1:0]             winner, winner_n;
   logic                   ball_run_n, ball_reset_n;
   logic [LEDS_W-1:0]      leds_n;

   assign start_edge = start_i & ~start_q;
   assign frame_step = (frame_cnt == '1) ? frame_cnt : frame_cnt + 1'b1;

   always_comb begin
      state_n     = state;
      frame_cnt_n = frame_cnt;
      score_l_n   = score_l;
      score_r_n   = score_r;
      serve_dir_n = serve_dir;
      winner_n    = winner;

      case (state)
         S_IDLE: begin
            score_l_n = '0;
            score_r_n = '0;
            if (start_edge) state_n = S_SERVE;
         end
         S_SERVE: begin
            if (new_frame_i) begin
               frame_cnt_n = frame_step;
               if (frame_step == SERVE_CNT) state_n = S_PLAY;
            end
         end
         S_PLAY: begin
            // A simultaneous double miss is a replay: no score, serve side kept.
            if (miss_left_i && miss_right_i) begin
               state_n = S_POINT;
            end else if (miss_left_i) begin
               score_r_n   = score_r + 1'b1;
               serve_dir_n = 1'b0;
               state_n     = S_POINT;
            end else if (miss_right_i) begin
               score_l_n   = score_l + 1'b1;
               serve_dir_n = 1'b1;
               state_n     = S_POINT;
            end
         end
         S_POINT: begin
            if (new_frame_i) begin
               frame_cnt_n = frame_step;
               if (frame_step == POINT_CNT) begin
                  if (score_l == WIN || score_r == WIN) begin
                     state_n  = S_OVER;
                     winner_n = {score_r == WIN, score_l == WIN};
                  end else begin
                     state_n = S_SERVE;
                  end
               end
            end
         end
         S_OVER: begin
            if (start_edge) begin
               score_l_n   = '0;
               score_r_n   = '0;
               winner_n    = 2'b00;
               serve_dir_n = 1'b0;
               state_n     = S_SERVE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Entry clear also swallows any frame pulse seen on the entering cycle.
      if (state_n != state && (state_n == S_SERVE || state_n == S_POINT))
         frame_cnt_n = '0;

      ball_run_n   = (state_n == S_PLAY);
      ball_reset_n = !ball_run_n;

      leds_n = '0;
`ifdef MATCH_SEQUENCER_SCORE_LEDS_EN
      for (int i = 0; i < LEDS_W; i++) begin
         if (i < SCORE_W)
            leds_n[i] = score_l_n[i];
         else if (i < 2 * SCORE_W)
            leds_n[i] = score_r_n[i-SCORE_W];
      end
`else
      leds_n[4:0] = 5'(5'b00001 << state_n);
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= S_IDLE;
         start_q      <= 1'b1;
         frame_cnt    <= '0;
         score_l      <= '0;
         score_r      <= '0;
         serve_dir    <= 1'b0;
         winner       <= 2'b00;
         ball_run_o   <= 1'b0;
         ball_reset_o <= 1'b1;
         leds_o       <= '0;
      end else begin
         state        <= state_n;
         start_q      <= start_i;
         frame_cnt    <= frame_cnt_n;
         score_l      <= score_l_n;
         score_r      <= score_r_n;
         serve_dir    <= serve_dir_n;
         winner       <= winner_n;
         ball_run_o   <= ball_run_n;
         ball_reset_o <= ball_reset_n;
         leds_o       <= leds_n;
      end
   end

   assign state_o     = state;
   assign score_l_o   = score_l;
   assign score_r_o   = score_r;
   assign serve_dir_o = serve_dir;
   assign winner_o    = winner;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with short frame counts and WIN_SCORE = 2.
module tb_match_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_ni = 1'b1;
   logic       new_frame_i = 1'b0;
   logic       start_i = 1'b0;
   logic       miss_left_i = 1'b0;
   logic       miss_right_i = 1'b0;
   logic       ball_run_o, ball_reset_o, serve_dir_o;
   logic [3:0] score_l_o, score_r_o;
   logic [1:0] winner_o;
   logic [2:0] state_o;
   logic [7:0] leds_o;

   int checks = 0;
   int fails  = 0;

   match_sequencer #(
      .SCORE_W(4), .WIN_SCORE(2), .SERVE_FRAMES(3), .POINT_FRAMES(2),
      .FRAME_CNT_W(8), .LEDS_W(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .new_frame_i(new_frame_i),
      .start_i(start_i), .miss_left_i(miss_left_i), .miss_right_i(miss_right_i),
      .ball_run_o(ball_run_o), .ball_reset_o(ball_reset_o),
      .serve_dir_o(serve_dir_o), .score_l_o(score_l_o), .score_r_o(score_r_o),
      .winner_o(winner_o), .state_o(state_o), .leds_o(leds_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_leds(input int st, input int sl, input int sr);
`ifdef MATCH_SEQUENCER_SCORE_LEDS_EN
      return {sr[3:0], sl[3:0]};
`else
      return 8'(1 << st);
`endif
   endfunction

   // Full-state check: state, scores, ball controls and LED pattern.
   task automatic chk_all(input string tag, input int st, input int sl, input int sr,
                          input logic run);
      chk({tag, ".state"}, 32'(state_o), 32'(st));
      chk({tag, ".score_l"}, 32'(score_l_o), 32'(sl));
      chk({tag, ".score_r"}, 32'(score_r_o), 32'(sr));
      chk({tag, ".run"}, 32'(ball_run_o), 32'(run));
      chk({tag, ".reset"}, 32'(ball_reset_o), 32'(!run));
      chk({tag, ".leds"}, 32'(leds_o), 32'(exp_leds(st, sl, sr)));
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         new_frame_i = 1'b1;
         tick();
         new_frame_i = 1'b0;
         tick();
      end
   endtask

   task automatic miss(input logic l, input logic r);
      miss_left_i  = l;
      miss_right_i = r;
      tick();
      miss_left_i  = 1'b0;
      miss_right_i = 1'b0;
   endtask

   initial begin
      // Reset with the start key already held.
      start_i = 1'b1;
      #3 rst_ni = 1'b0;
      #1;
      chk("rst_async.leds", 32'(leds_o), 32'h0);
      chk("rst_async.state", 32'(state_o), 32'd0);
      chk("rst_async.reset", 32'(ball_reset_o), 32'd1);
      chk("rst_async.winner", 32'(winner_o), 32'd0);
      chk("rst_async.dir", 32'(serve_dir_o), 32'd0);
      tick();
      tick();
      rst_ni = 1'b1;
      tick();
      tick();
      tick();
      chk_all("held_start", 0, 0, 0, 1'b0);

      // Release and press: SERVE one cycle later.
      start_i = 1'b0;
      tick();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk_all("serve_entry", 1, 0, 0, 1'b0);

      frames(2);
      chk_all("serve_2frames", 1, 0, 0, 1'b0);
      frames(1);
      chk_all("play_entry", 2, 0, 0, 1'b1);

      // Left miss: right scores, serve toward left.
      miss(1'b1, 1'b0);
      chk_all("miss_left", 3, 0, 1, 1'b0);
      chk("miss_left.dir", 32'(serve_dir_o), 32'd0);
      miss(1'b0, 1'b1);
      chk_all("miss_in_point", 3, 0, 1, 1'b0);
      frames(1);
      chk_all("point_1frame", 3, 0, 1, 1'b0);
      frames(1);
      chk_all("point_to_serve", 1, 0, 1, 1'b0);
      miss(1'b1, 1'b0);
      chk_all("miss_in_serve", 1, 0, 1, 1'b0);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk_all("start_in_serve", 1, 0, 1, 1'b0);
      frames(3);
      chk_all("play2", 2, 0, 1, 1'b1);

      // Double miss: replay, no score.
      miss(1'b1, 1'b1);
      chk_all("double_miss", 3, 0, 1, 1'b0);
      chk("double_miss.dir", 32'(serve_dir_o), 32'd0);
      frames(2);
      frames(3);
      chk_all("play3", 2, 0, 1, 1'b1);

      // Right miss: left scores, serve toward right.
      miss(1'b0, 1'b1);
      chk_all("miss_right", 3, 1, 1, 1'b0);
      chk("miss_right.dir", 32'(serve_dir_o), 32'd1);
      frames(2);
      chk_all("no_win_yet", 1, 1, 1, 1'b0);
      frames(3);
      chk_all("play4", 2, 1, 1, 1'b1);

      // Miss and frame together: miss wins, frame not counted.
      miss_right_i = 1'b1;
      new_frame_i  = 1'b1;
      tick();
      miss_right_i = 1'b0;
      new_frame_i  = 1'b0;
      chk_all("miss_plus_frame", 3, 2, 1, 1'b0);
      frames(1);
      chk_all("point_not_early", 3, 2, 1, 1'b0);
      frames(1);
      chk_all("over", 4, 2, 1, 1'b0);
      chk("over.winner", 32'(winner_o), 32'd1);
      miss(1'b1, 1'b0);
      chk_all("over_frozen", 4, 2, 1, 1'b0);

      // Restart with a frame pulse on the SERVE entry cycle.
      start_i     = 1'b1;
      new_frame_i = 1'b1;
      tick();
      start_i     = 1'b0;
      new_frame_i = 1'b0;
      chk_all("restart", 1, 0, 0, 1'b0);
      chk("restart.winner", 32'(winner_o), 32'd0);
      chk("restart.dir", 32'(serve_dir_o), 32'd0);
      frames(2);
      chk_all("entry_frame_ignored", 1, 0, 0, 1'b0);
      frames(1);
      chk_all("play5", 2, 0, 0, 1'b1);

      miss(1'b0, 1'b1);
      frames(2);
      frames(3);
      chk_all("play6", 2, 1, 0, 1'b1);

      // Mid-play reset, between clock edges.
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst.state", 32'(state_o), 32'd0);
      chk("midrst.run", 32'(ball_run_o), 32'd0);
      chk("midrst.reset", 32'(ball_reset_o), 32'd1);
      chk("midrst.score_l", 32'(score_l_o), 32'd0);
      chk("midrst.dir", 32'(serve_dir_o), 32'd0);
      chk("midrst.leds", 32'(leds_o), 32'h0);
      tick();
      rst_ni = 1'b1;
      tick();
      chk_all("post_rst_idle", 0, 0, 0, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
